// File: rtl/fa_pkg.sv
// Shared types and helpers for the 1-bit full adder cell and its pipeline.
package fa_pkg;

  localparam int FA_MAX_LATENCY = 4;

  typedef struct packed {
    logic sum;
    logic cout;
  } fa_res_t;

  function automatic fa_res_t fa_eval(input logic a, input logic b, input logic cin);
    fa_res_t r;
    r.sum  = a ^ b ^ cin;
    r.cout = (a & b) | (cin & (a ^ b));
    return r;
  endfunction

endpackage

// File: rtl/fa_core.sv
// Combinational 1-bit full adder, pure dataflow.
module fa_core (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic cout
);

  logic half;

  assign half = a ^ b;
  assign sum  = half ^ cin;
  assign cout = (a & b) | (cin & half);

endmodule

// File: rtl/full_adder_1bit_dataflow.sv
// Registered 1-bit full adder with a LATENCY-deep valid-qualified pipeline.
// Optional saturating statistics counters are enabled by the FA_STATS_EN macro.
module full_adder_1bit_dataflow
  import fa_pkg::*;
#(
  parameter int LATENCY = 1,
  parameter int CNT_W   = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic             a,
  input  logic             b,
  input  logic             cin,
  output logic             out_valid,
  output logic             sum,
  output logic             cout,
  output logic [CNT_W-1:0] ops_cnt,
  output logic [CNT_W-1:0] carry_cnt
);

  fa_res_t res_c;

  fa_core u_core (
    .a    (a),
    .b    (b),
    .cin  (cin),
    .sum  (res_c.sum),
    .cout (res_c.cout)
  );

  generate
    if (LATENCY < 0 || LATENCY > FA_MAX_LATENCY) begin : g_bad_latency
      $error("full_adder_1bit_dataflow: LATENCY=%0d outside 0..%0d", LATENCY, FA_MAX_LATENCY);
    end

    if (LATENCY == 0) begin : g_comb
      // Result follows the inputs regardless of in_valid; clk/rst_n only feed the counters.
      logic unused_ok;
      assign unused_ok = ^{clk, rst_n};
      assign out_valid = in_valid;
      assign sum       = res_c.sum;
      assign cout      = res_c.cout;
    end else begin : g_pipe
      logic    [LATENCY-1:0] vld_p;
      fa_res_t [LATENCY-1:0] res_p;

      // Stage boundaries: each stage only loads data when its upstream valid is set.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          vld_p <= '0;
          res_p <= '0;
        end else begin
          vld_p[0] <= in_valid;
          if (in_valid) res_p[0] <= res_c;
          for (int i = 1; i < LATENCY; i++) begin
            vld_p[i] <= vld_p[i-1];
            if (vld_p[i-1]) res_p[i] <= res_p[i-1];
          end
        end
      end

      assign out_valid = vld_p[LATENCY-1];
      assign sum       = res_p[LATENCY-1].sum;
      assign cout      = res_p[LATENCY-1].cout;
    end
  endgenerate

`ifdef FA_STATS_EN
  logic [CNT_W-1:0] ops_q;
  logic [CNT_W-1:0] carry_q;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ops_q   <= '0;
      carry_q <= '0;
    end else if (out_valid) begin
      ops_q <= sat_inc(ops_q);
      if (cout) carry_q <= sat_inc(carry_q);
    end
  end

  assign ops_cnt   = ops_q;
  assign carry_cnt = carry_q;
`else
  assign ops_cnt   = '0;
  assign carry_cnt = '0;
`endif

endmodule

// File: tb/tb_full_adder_1bit_dataflow.sv
// Bench for full_adder_1bit_dataflow: LATENCY 0/1/3 instances against a history-based model.
module tb_full_adder_1bit_dataflow;

  localparam int CW = 2;
`ifdef FA_STATS_EN
  localparam bit STATS   = 1'b1;
  localparam int EXP_SAT = 3;
`else
  localparam bit STATS   = 1'b0;
  localparam int EXP_SAT = 0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic in_valid = 1'b0, a = 1'b0, b = 1'b0, cin = 1'b0;
  logic ov0, s0, c0, ov1, s1, c1, ov3, s3, c3;
  logic [CW-1:0] op0, ca0, op1, ca1, op3, ca3;

  full_adder_1bit_dataflow #(.LATENCY(0), .CNT_W(CW)) u_l0 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .a(a), .b(b), .cin(cin),
    .out_valid(ov0), .sum(s0), .cout(c0), .ops_cnt(op0), .carry_cnt(ca0));
  full_adder_1bit_dataflow #(.LATENCY(1), .CNT_W(CW)) u_l1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .a(a), .b(b), .cin(cin),
    .out_valid(ov1), .sum(s1), .cout(c1), .ops_cnt(op1), .carry_cnt(ca1));
  full_adder_1bit_dataflow #(.LATENCY(3), .CNT_W(CW)) u_l3 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .a(a), .b(b), .cin(cin),
    .out_valid(ov3), .sum(s3), .cout(c3), .ops_cnt(op3), .carry_cnt(ca3));

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  bit hv [4096];
  bit hs [4096];
  bit hc [4096];
  int ne = 0;
  int rst_base = 0;
  bit cmp_en = 1'b0;

  task automatic chk(input string nm, input int got, input int exp);
    checks++;
    if (got != exp) begin
      failures++;
      $display("FAIL %s got=%0d expected=%0d at %0t", nm, got, exp, $time);
    end
  endtask

  // Record every accepted edge: bit count of a+b+cin gives sum (odd) and carry (>=2).
  always @(posedge clk) begin
    if (rst_n) begin
      int tot;
      tot = int'(a) + int'(b) + int'(cin);
      hv[ne] = in_valid;
      hs[ne] = (tot % 2) == 1;
      hc[ne] = tot >= 2;
      ne++;
    end
  end

  always @(negedge rst_n) rst_base = ne;

  // Output of an N-deep pipe: valid of the record N edges back, data of the newest valid record at or before it.
  function automatic void model(input int n, output int v, output int s, output int c);
    int idx;
    idx = ne - n;
    v = 0; s = 0; c = 0;
    if (idx >= rst_base) v = int'(hv[idx]);
    for (int j = idx; j >= rst_base; j--) begin
      if (hv[j]) begin
        s = int'(hs[j]);
        c = int'(hc[j]);
        break;
      end
    end
  endfunction

  function automatic int cnt_model(input int n, input bit carry_only);
    int cnt;
    cnt = 0;
    for (int j = rst_base; j <= ne - 1 - n; j++)
      if (hv[j] && (!carry_only || hc[j])) cnt++;
    if (cnt > (1 << CW) - 1) cnt = (1 << CW) - 1;
    return STATS ? cnt : 0;
  endfunction

  always @(negedge clk) begin
    if (cmp_en) begin
      int v, s, c, tot;
      tot = int'(a) + int'(b) + int'(cin);
      chk("l0_valid", int'(ov0), int'(in_valid));
      chk("l0_sum", int'(s0), tot % 2);
      chk("l0_cout", int'(c0), int'(tot >= 2));
      model(1, v, s, c);
      chk("l1_valid", int'(ov1), v);
      chk("l1_sum", int'(s1), s);
      chk("l1_cout", int'(c1), c);
      model(3, v, s, c);
      chk("l3_valid", int'(ov3), v);
      chk("l3_sum", int'(s3), s);
      chk("l3_cout", int'(c3), c);
      chk("l0_ops", int'(op0), cnt_model(0, 1'b0));
      chk("l0_carry", int'(ca0), cnt_model(0, 1'b1));
      chk("l1_ops", int'(op1), cnt_model(1, 1'b0));
      chk("l1_carry", int'(ca1), cnt_model(1, 1'b1));
      chk("l3_ops", int'(op3), cnt_model(3, 1'b0));
      chk("l3_carry", int'(ca3), cnt_model(3, 1'b1));
    end
  end

  task automatic step(input logic v, input logic x, input logic y, input logic z);
    in_valid = v; a = x; b = y; cin = z;
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_zero(input string tag);
    chk({tag, "_l1_valid"}, int'(ov1), 0);
    chk({tag, "_l1_sum"}, int'(s1), 0);
    chk({tag, "_l1_cout"}, int'(c1), 0);
    chk({tag, "_l3_valid"}, int'(ov3), 0);
    chk({tag, "_l3_sum"}, int'(s3), 0);
    chk({tag, "_l3_cout"}, int'(c3), 0);
    chk({tag, "_l1_ops"}, int'(op1), 0);
    chk({tag, "_l1_carry"}, int'(ca1), 0);
    chk({tag, "_l0_ops"}, int'(op0), 0);
  endtask

  logic [1:0] tt [8] = '{2'b00, 2'b10, 2'b10, 2'b01, 2'b10, 2'b01, 2'b01, 2'b11};

  initial begin
    #1 rst_n = 1'b0;
    cmp_en = 1'b1;
    #1 check_reset_zero("por");
    @(posedge clk);
    @(posedge clk);
    #1 rst_n = 1'b1;

    // Directed vectors, one cycle latency on the LATENCY=1 instance.
    step(1, 0, 0, 0);
    chk("vec000_valid", int'(ov1), 1); chk("vec000_sum", int'(s1), 0); chk("vec000_cout", int'(c1), 0);
    step(1, 1, 1, 1);
    chk("vec111_sum", int'(s1), 1); chk("vec111_cout", int'(c1), 1);
    step(1, 1, 0, 1);
    chk("vec101_sum", int'(s1), 0); chk("vec101_cout", int'(c1), 1);

    // All eight combinations back-to-back against the literal truth table.
    for (int i = 0; i < 8; i++) begin
      logic [2:0] iv;
      iv = 3'(i);
      step(1, iv[2], iv[1], iv[0]);
      chk("exh_valid", int'(ov1), 1);
      chk("exh_sum", int'(s1), int'(tt[i][1]));
      chk("exh_cout", int'(c1), int'(tt[i][0]));
    end

    // Gap: last result held while out_valid is low.
    step(1, 1, 1, 0);
    chk("gap_first_sum", int'(s1), 0); chk("gap_first_cout", int'(c1), 1);
    for (int i = 0; i < 3; i++) begin
      step(0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      chk("gap_valid", int'(ov1), 0);
      chk("gap_sum", int'(s1), 0);
      chk("gap_cout", int'(c1), 1);
    end

    // LATENCY=0 immediate and LATENCY=3 after three cycles.
    in_valid = 1; a = 0; b = 1; cin = 1;
    #1;
    chk("l0_011_valid", int'(ov0), 1); chk("l0_011_sum", int'(s0), 0); chk("l0_011_cout", int'(c0), 1);
    @(posedge clk);
    #1;
    step(0, 0, 0, 0);
    chk("l3_011_early", int'(ov3), 0);
    step(0, 0, 0, 0);
    chk("l3_011_valid", int'(ov3), 1); chk("l3_011_sum", int'(s3), 0); chk("l3_011_cout", int'(c3), 1);

    // Mid-cycle asynchronous reset, then saturating counters.
    step(1, 1, 1, 1);
    #2 rst_n = 1'b0;
    #1 check_reset_zero("async");
    @(posedge clk);
    #1 rst_n = 1'b1;
    for (int i = 0; i < 5; i++) step(1, 1, 1, 0);
    step(0, 0, 0, 0);
    step(0, 0, 0, 0);
    chk("sat_l1_ops", int'(op1), EXP_SAT);
    chk("sat_l1_carry", int'(ca1), EXP_SAT);
    chk("sat_l0_ops", int'(op0), EXP_SAT);

    // Randomised traffic with one reset partway through.
    for (int n = 0; n < 400; n++) begin
      if (n == 200) begin
        #2 rst_n = 1'b0;
        @(posedge clk);
        #1 rst_n = 1'b1;
      end
      step(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
           1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end

    @(negedge clk);
    #1 cmp_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    failures++;
    $display("FAIL watchdog expired");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

endmodule
